// File: rtl/num_ascii_tx_pkg.sv
// num_ascii_tx_pkg
// Shared constants for the numeric-to-ASCII transmit path: separator
// encodings, ASCII byte values and the default matrix element width.
// No ports; imported with "import num_ascii_tx_pkg::*;".
package num_ascii_tx_pkg;

  localparam int ELEMENT_WIDTH = 8;

  localparam logic [1:0] SEP_NONE  = 2'd0;
  localparam logic [1:0] SEP_SPACE = 2'd1;
  localparam logic [1:0] SEP_CRLF  = 2'd2;
  localparam logic [1:0] SEP_COMMA = 2'd3;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;

endpackage

// File: rtl/num_ascii_tx_bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle,
// MSB first.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_bin and clear the BCD register
//   i_bin          : unsigned binary value
//   o_done         : high in the cycle whose closing edge performs the last
//                    shift; o_bcd is final from that edge on
//   o_bcd          : packed BCD result, digit 0 in the low nibble
module bin2bcd_seq #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int NUM_DIGITS    = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [ELEMENT_WIDTH-1:0]  i_bin,
  output logic                      o_done,
  output logic [4*NUM_DIGITS-1:0]   o_bcd
);

  localparam int CW = $clog2(ELEMENT_WIDTH + 1);

  logic [ELEMENT_WIDTH-1:0] r_bin;
  logic [4*NUM_DIGITS-1:0]  r_bcd;
  logic [CW-1:0]            r_cnt;
  logic [4*NUM_DIGITS-1:0]  w_adj;

  // Add 3 to every nibble >= 5 so that the following shift carries correctly.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(ELEMENT_WIDTH);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[4*NUM_DIGITS-2:0], r_bin[ELEMENT_WIDTH-1]};
      r_bin <= {r_bin[ELEMENT_WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Early completion flag lets the caller leave its wait state on the very
  // edge that produces the final digits.
  assign o_done = (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/num_ascii_tx.sv
// num_ascii_tx
// Prints one matrix element as decimal ASCII over the shared UART TX port,
// optionally followed by a separator (none, space, CR LF, comma).
// Optional feature macro: NUM_ASCII_TX_SIGNED_EN -- treat i_value as two's
// complement and emit a leading '-' for negative numbers.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request, sampled only while idle
//   i_value        : number to print, captured with i_start
//   i_sep_sel      : separator select, captured with i_start
//   i_abort        : synchronous cancel
//   o_busy         : high whenever not idle
//   o_done         : one-cycle pulse after the last byte is handed off
//   o_tx_data      : byte to the UART transmitter
//   o_tx_start     : one-cycle launch pulse to the UART transmitter
//   i_tx_busy      : UART transmitter busy
module num_ascii_tx #(
  parameter int ELEMENT_WIDTH = num_ascii_tx_pkg::ELEMENT_WIDTH,
  parameter int NUM_DIGITS    = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ELEMENT_WIDTH-1:0] i_value,
  input  logic [1:0]               i_sep_sel,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_busy
);

  import num_ascii_tx_pkg::*;

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SEND_SIGN, S_SEND_DIGIT,
    S_SEND_SEP1, S_SEND_SEP2, S_GUARD, S_FINISH
  } state_t;

  state_t                   r_state, w_next, r_ret, w_ret_next, w_after_digits;
  logic [1:0]               r_sep;
  logic                     r_neg, r_lead, r_tx_start;
  logic [7:0]               r_tx_data, w_byte;
  logic [IW-1:0]            r_dig_idx, w_idx, w_msd;
  logic [3:0]               w_nibble;
  logic                     w_accept, w_neg, w_cvt_done, w_launch, w_can_send;
  logic [ELEMENT_WIDTH-1:0] w_mag;
  logic [4*NUM_DIGITS-1:0]  w_bcd;

  assign w_accept = (r_state == S_IDLE) && i_start;

`ifdef NUM_ASCII_TX_SIGNED_EN
  // The most negative input negates to itself, which read as unsigned is
  // exactly its magnitude.
  assign w_neg = i_value[ELEMENT_WIDTH-1];
  assign w_mag = w_neg ? (~i_value + ELEMENT_WIDTH'(1)) : i_value;
`else
  assign w_neg = 1'b0;
  assign w_mag = i_value;
`endif

  bin2bcd_seq #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .NUM_DIGITS    (NUM_DIGITS)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_accept),
    .i_bin   (w_mag),
    .o_done  (w_cvt_done),
    .o_bcd   (w_bcd)
  );

  // Highest nonzero digit; stays 0 for a zero value so one "0" is printed.
  always_comb begin
    w_msd = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_bcd[4*d +: 4] != 4'd0) w_msd = IW'(d);
    end
  end

  assign w_idx = r_lead ? w_msd : r_dig_idx;

  always_comb begin
    w_nibble = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_idx == IW'(d)) w_nibble = w_bcd[4*d +: 4];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; r_ret remembers where GUARD hands control back to.
  always_comb begin
    w_next         = r_state;
    w_ret_next     = r_ret;
    w_after_digits = (r_sep == SEP_NONE) ? S_FINISH : S_SEND_SEP1;
    case (r_state)
      S_IDLE:       if (i_start) w_next = S_CONVERT;
      S_CONVERT:    if (w_cvt_done) w_next = r_neg ? S_SEND_SIGN : S_SEND_DIGIT;
      S_SEND_SIGN:  if (w_launch) begin
                      w_next     = S_GUARD;
                      w_ret_next = S_SEND_DIGIT;
                    end
      S_SEND_DIGIT: if (w_launch) begin
                      w_next     = S_GUARD;
                      w_ret_next = (w_idx == '0) ? w_after_digits : S_SEND_DIGIT;
                    end
      S_SEND_SEP1:  if (w_launch) begin
                      w_next     = S_GUARD;
                      w_ret_next = (r_sep == SEP_CRLF) ? S_SEND_SEP2 : S_FINISH;
                    end
      S_SEND_SEP2:  if (w_launch) begin
                      w_next     = S_GUARD;
                      w_ret_next = S_FINISH;
                    end
      S_GUARD:      w_next = r_ret;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Output decode; abort suppresses both a pending launch and the done pulse.
  always_comb begin
    w_can_send = !i_tx_busy && !r_tx_start && !i_abort;
    w_launch   = 1'b0;
    w_byte     = 8'h00;
    case (r_state)
      S_SEND_SIGN: begin
        w_launch = w_can_send;
        w_byte   = ASCII_MINUS;
      end
      S_SEND_DIGIT: begin
        w_launch = w_can_send;
        w_byte   = ASCII_ZERO + {4'h0, w_nibble};
      end
      S_SEND_SEP1: begin
        w_launch = w_can_send;
        case (r_sep)
          SEP_CRLF:  w_byte = ASCII_CR;
          SEP_COMMA: w_byte = ASCII_COMMA;
          default:   w_byte = ASCII_SPACE;
        endcase
      end
      S_SEND_SEP2: begin
        w_launch = w_can_send;
        w_byte   = ASCII_LF;
      end
      default: begin
        w_launch = 1'b0;
        w_byte   = 8'h00;
      end
    endcase
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_FINISH) && !i_abort;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ret      <= S_IDLE;
      r_sep      <= SEP_NONE;
      r_neg      <= 1'b0;
      r_lead     <= 1'b0;
      r_dig_idx  <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= w_launch;
      r_ret      <= w_ret_next;
      if (w_launch) r_tx_data <= w_byte;
      if (w_accept) begin
        r_sep <= i_sep_sel;
        r_neg <= w_neg;
      end
      if ((r_state == S_CONVERT) && w_cvt_done) r_lead <= 1'b1;
      if ((r_state == S_SEND_DIGIT) && w_launch) begin
        r_lead    <= 1'b0;
        r_dig_idx <= w_idx - IW'(1);
      end
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_num_ascii_tx.sv
// tb_num_ascii_tx
// Self-checking bench for num_ascii_tx: table vectors, hand-written abort and
// reset sequences, and randomized values against a decimal-printing model.
module tb_num_ascii_tx;

  logic       clk, rstN, start, abort, txBusy;
  logic [7:0] value;
  logic [1:0] sepSel;
  logic       busy, done, txStart;
  logic [7:0] txData;

  num_ascii_tx dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_start    (start),
    .i_value    (value),
    .i_sep_sel  (sepSel),
    .i_abort    (abort),
    .o_busy     (busy),
    .o_done     (done),
    .o_tx_data  (txData),
    .o_tx_start (txStart),
    .i_tx_busy  (txBusy)
  );

  typedef struct {
    logic [7:0] v;
    logic [1:0] sep;
    int         bl;
    string      exp;
  } vec_t;

  vec_t vecs[$];

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int busyLen = 0;
  int busyCnt = 0;
  int doneCnt = 0;
  int doneCyc = 0;
  int lastTxCyc = 0;
  int firstTxCyc = 0;
  int spacingErr = 0;
  byte unsigned rxQ[$];
  byte unsigned expQ[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // UART stand-in: records launched bytes and holds tx_busy for busyLen cycles.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (busyCnt > 0) busyCnt--;
      if (txStart === 1'b1) begin
        if (rxQ.size() == 0) firstTxCyc = cyc;
        else if (cyc - lastTxCyc < 2) spacingErr++;
        lastTxCyc = cyc;
        rxQ.push_back(txData);
        busyCnt = busyLen;
      end
      txBusy = (busyCnt > 0);
      if (done === 1'b1) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] packQ(input byte unsigned q[$]);
    logic [63:0] acc = '0;
    foreach (q[i]) acc = (acc << 8) | 64'(q[i]);
    return acc;
  endfunction

  task automatic strToQ(input string s);
    expQ.delete();
    for (int i = 0; i < s.len(); i++) expQ.push_back(8'(s[i]));
  endtask

  // Reference: print the number in decimal with plain arithmetic.
  task automatic buildExpected(input logic [7:0] v, input logic [1:0] sep);
    int mag;
    byte unsigned digs[$];
    expQ.delete();
    mag = int'(v);
`ifdef NUM_ASCII_TX_SIGNED_EN
    if (v[7]) begin
      mag = 256 - int'(v);
      expQ.push_back(8'h2D);
    end
`endif
    do begin
      digs.push_front(8'(48 + mag % 10));
      mag = mag / 10;
    end while (mag > 0);
    foreach (digs[i]) expQ.push_back(digs[i]);
    case (sep)
      2'd1: expQ.push_back(8'h20);
      2'd2: begin expQ.push_back(8'h0D); expQ.push_back(8'h0A); end
      2'd3: expQ.push_back(8'h2C);
      default: ;
    endcase
  endtask

  task automatic launch(input logic [7:0] v, input logic [1:0] sep, input int bl,
                        output int startCyc);
    busyLen = bl;
    rxQ.delete();
    doneCnt = 0;
    spacingErr = 0;
    firstTxCyc = -1;
    lastTxCyc = 0;
    doneCyc = 0;
    @(negedge clk);
    start = 1'b1;
    value = v;
    sepSel = sep;
    startCyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    value = 8'($urandom);
    sepSel = 2'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic [1:0] sep,
                               input int bl, input int extraStart, input string name);
    int startCyc;
    int timedOut;
    launch(v, sep, bl, startCyc);
    if (extraStart != 0) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      value = v + 8'd1;
      @(negedge clk);
      start = 1'b0;
    end
    timedOut = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (doneCnt > 0 && busy == 1'b0) begin
        timedOut = 0;
        break;
      end
    end
    repeat (bl + 4) @(negedge clk);
    checkOutput({name, " timeout"}, 64'(timedOut), 64'd0);
    checkOutput({name, " byte count"}, 64'(rxQ.size()), 64'(expQ.size()));
    checkOutput({name, " bytes"}, packQ(rxQ), packQ(expQ));
    checkOutput({name, " done count"}, 64'(doneCnt), 64'd1);
    checkOutput({name, " first tx latency"}, 64'(firstTxCyc - startCyc), 64'd9);
    checkOutput({name, " tx spacing"}, 64'(spacingErr), 64'd0);
    checkOutput({name, " done after last byte"}, 64'(doneCyc > lastTxCyc), 64'd1);
  endtask

  task automatic waitFirstByte(input string name);
    int seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (rxQ.size() > 0) begin
        seen = 1;
        break;
      end
    end
    checkOutput({name, " first byte seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int sc;
    logic [7:0] rv;
    logic [1:0] rs;
    rstN = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    value = 8'd0;
    sepSel = 2'd0;

    vecs.push_back('{8'd0,   2'd1, 0, "0 "});
    vecs.push_back('{8'd7,   2'd0, 0, "7"});
    vecs.push_back('{8'd100, 2'd3, 2, "100,"});
    vecs.push_back('{8'd45,  2'd2, 1, "45\015\012"});
    vecs.push_back('{8'd127, 2'd1, 3, "127 "});
    vecs.push_back('{8'd10,  2'd0, 0, "10"});
    vecs.push_back('{8'd9,   2'd3, 0, "9,"});

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset tx_start", 64'(txStart), 64'd0);
    checkOutput("reset tx_data", 64'(txData), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      strToQ(vecs[i].exp);
      applyStimulus(vecs[i].v, vecs[i].sep, vecs[i].bl, 0, $sformatf("vec%0d", i));
    end

`ifdef NUM_ASCII_TX_SIGNED_EN
    strToQ("-1\015\012");
    applyStimulus(8'hFF, 2'd2, 100, 0, "minus one crlf slow");
    strToQ("-128,");
    applyStimulus(8'h80, 2'd3, 0, 0, "most negative");
`else
    strToQ("255\015\012");
    applyStimulus(8'd255, 2'd2, 100, 0, "255 crlf slow");
    strToQ("128,");
    applyStimulus(8'h80, 2'd3, 0, 0, "128 comma");
`endif

    strToQ("7");
    applyStimulus(8'd7, 2'd0, 10, 1, "start while busy");

    // Abort in GUARD right after the first digit goes out.
    launch(8'd123, 2'd1, 3, sc);
    waitFirstByte("abort");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort busy next cycle", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("abort bytes", packQ(rxQ), 64'h31);
    checkOutput("abort no done", 64'(doneCnt), 64'd0);
    strToQ("45");
    applyStimulus(8'd45, 2'd0, 2, 0, "after abort");

    // Reset asserted mid-CONVERT, between clock edges.
    launch(8'd88, 2'd1, 0, sc);
    repeat (3) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst convert busy", 64'(busy), 64'd0);
    checkOutput("rst convert tx_start", 64'(txStart), 64'd0);
    checkOutput("rst convert tx_data", 64'(txData), 64'd0);
    checkOutput("rst convert done", 64'(done), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Reset asserted while in GUARD after a launch.
    launch(8'd88, 2'd1, 0, sc);
    waitFirstByte("rst guard");
    rstN = 1'b0;
    #1;
    checkOutput("rst guard busy", 64'(busy), 64'd0);
    checkOutput("rst guard tx_start", 64'(txStart), 64'd0);
    checkOutput("rst guard tx_data", 64'(txData), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    strToQ("88,");
    applyStimulus(8'd88, 2'd3, 1, 0, "after reset");

    for (int n = 0; n < 30; n++) begin
      rv = 8'($urandom_range(0, 255));
      rs = 2'($urandom_range(0, 3));
      buildExpected(rv, rs);
      applyStimulus(rv, rs, $urandom_range(0, 4), 0, $sformatf("rand%0d v=%0d", n, rv));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
